// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the clock-divider configuration front-end.
// Holds the controller state encoding, the default ratio width and the
// ratio driven out of reset (also used by the divider bench).
package clk_div_ctrl_pkg;

  // Width of the divider's ratio input.
  localparam int unsigned CLK_DIV_RATIO_W = 8;

  // Ratio presented to the divider out of reset; 1 means bypass.
  localparam int unsigned CLK_DIV_RESET_RATIO = 1;

  // Ratio-switch sequence: gate off, drain, load ratio, settle, re-enable.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/clk_div_ctrl_timer.sv
// Loadable down-counter used for the drain and settle intervals.
// Latency: value updates on the edge after load/dec; zero is combinational from value.
// Backpressure: none; the caller decides when to load and when to count.
// Ports: clk/rst (async active-high), load (reload LOAD_VAL, wins over dec),
//        dec (count down by one), value (current count), zero (value == 0).
module clk_div_ctrl_timer
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned LOAD_VAL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= CNT_W'(LOAD_VAL);
    end else if (dec) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// Configuration front-end owning the clock divider's ratio and enable pins.
// Latency: fast path 1 cycle; switch path 2*SETTLE_CYCLES+1 cycles (macro defined).
// Backpressure: o_cfg_ready drops for the whole switch sequence; tied high otherwise.
// Ports: i_ref_clk/i_rst (async active-high); i_cfg_valid/o_cfg_ready handshake
//        carrying i_cfg_ratio/i_cfg_enable; o_div_ratio/o_clk_en to the divider;
//        o_busy (switch in progress); o_cfg_err (one-cycle pulse, ratio 0 accepted).
// Build option: CLK_DIV_CTRL_SAFE_SWITCH_EN enables the gated ratio-switch sequence;
//        without it every accept updates ratio and enable together.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned RATIO_W       = CLK_DIV_RATIO_W,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RESET_RATIO   = CLK_DIV_RESET_RATIO
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [RATIO_W-1:0] i_cfg_ratio,
  input  logic               i_cfg_enable,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_busy,
  output logic               o_cfg_err
);

  localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(RESET_RATIO);

  logic               accept;
  logic               ratio_zero;
  logic [RATIO_W-1:0] norm_ratio;

  assign accept     = i_cfg_valid && o_cfg_ready;
  assign ratio_zero = (i_cfg_ratio == '0);
  // A zero ratio is meaningless to the divider; run it as bypass instead.
  assign norm_ratio = ratio_zero ? RATIO_W'(1) : i_cfg_ratio;

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= accept && ratio_zero;
    end
  end

`ifdef CLK_DIV_CTRL_SAFE_SWITCH_EN

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  ctrl_state_t        state;
  logic [RATIO_W-1:0] shadow_ratio;
  logic               shadow_en;
  logic               fast_path;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_zero;
  logic [CNT_W-1:0]   tmr_value;

  // Same ratio as already applied: only the enable changes, no need to gate.
  assign fast_path = (norm_ratio == o_div_ratio);

  // The counter is armed on entry to DRAIN and on LOAD (entry to SETTLE),
  // and counts down while waiting; it holds at zero on the exit cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state)
      ST_IDLE:             tmr_load = accept && !fast_path;
      ST_LOAD:             tmr_load = 1'b1;
      ST_DRAIN, ST_SETTLE: tmr_dec  = (tmr_value != '0);
      default:             ;
    endcase
  end

  clk_div_ctrl_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (SETTLE_CYCLES - 1)
  ) u_timer (
    .clk   (i_ref_clk),
    .rst   (i_rst),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_div_ratio  <= RST_RATIO;
      o_clk_en     <= 1'b0;
      o_cfg_ready  <= 1'b1;
      o_busy       <= 1'b0;
      shadow_ratio <= '0;
      shadow_en    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shadow_ratio <= norm_ratio;
            shadow_en    <= i_cfg_enable;
            if (fast_path) begin
              o_clk_en <= i_cfg_enable;
            end else begin
              o_clk_en    <= 1'b0;
              o_cfg_ready <= 1'b0;
              o_busy      <= 1'b1;
              state       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (tmr_zero) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_div_ratio <= shadow_ratio;
          state       <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            o_clk_en    <= shadow_en;
            o_cfg_ready <= 1'b1;
            o_busy      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`else

  // Always ready; an out-of-range SETTLE_CYCLES holds ready low so a
  // misconfigured build is visibly dead rather than subtly wrong.
  assign o_cfg_ready = (SETTLE_CYCLES >= 1);
  assign o_busy      = 1'b0;

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      o_div_ratio <= RST_RATIO;
      o_clk_en    <= 1'b0;
    end else if (accept) begin
      o_div_ratio <= norm_ratio;
      o_clk_en    <= i_cfg_enable;
    end
  end

`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomised scoreboard bench for clk_div_ctrl: a timeline model predicts the
// outputs after every clock edge, pushes them into a queue, and a monitor
// compares them against the DUT on the falling edge.
module tb_clk_div_ctrl;

  localparam int S = 4;
`ifdef CLK_DIV_CTRL_SAFE_SWITCH_EN
  localparam bit SAFE = 1'b1;
`else
  localparam bit SAFE = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_ratio;
  logic       cfg_enable;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       busy;
  logic       cfg_err;

  clk_div_ctrl #(
    .RATIO_W       (8),
    .SETTLE_CYCLES (S),
    .RESET_RATIO   (1)
  ) dut (
    .i_ref_clk    (clk),
    .i_rst        (rst),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_ratio  (cfg_ratio),
    .i_cfg_enable (cfg_enable),
    .o_div_ratio  (div_ratio),
    .o_clk_en     (clk_en),
    .o_busy       (busy),
    .o_cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ratio;
    logic       en;
    logic       rdy;
    logic       busy;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: settled ratio/enable plus an optional switch in flight,
  // described only by its start edge and target values.
  int         n;
  logic [7:0] m_ratio;
  logic       m_en;
  logic       m_acc;
  logic       sw_act;
  int         sw_t0;
  logic [7:0] sw_ratio;
  logic       sw_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_ratio = 8'd1;
    m_en    = 1'b0;
    m_acc   = 1'b0;
    sw_act  = 1'b0;
    sw_t0   = 0;
  endtask

  // Called once per rising edge with the inputs the DUT just sampled.
  task automatic model_edge(output obs_t o);
    logic [7:0] nr;
    int         el;
    n++;
    m_acc = cfg_valid && (!SAFE || !sw_act);
    nr    = (cfg_ratio == 8'd0) ? 8'd1 : cfg_ratio;
    if (sw_act && (n - sw_t0 == 2 * S + 1)) begin
      m_ratio = sw_ratio;
      m_en    = sw_en;
      sw_act  = 1'b0;
    end
    if (m_acc) begin
      if (!SAFE || nr == m_ratio) begin
        m_ratio = nr;
        m_en    = cfg_enable;
      end else begin
        sw_act   = 1'b1;
        sw_t0    = n;
        sw_ratio = nr;
        sw_en    = cfg_enable;
      end
    end
    o.err = m_acc && (cfg_ratio == 8'd0);
    if (sw_act) begin
      el      = n - sw_t0;
      o.ratio = (el >= S + 1) ? sw_ratio : m_ratio;
      o.en    = 1'b0;
      o.rdy   = 1'b0;
      o.busy  = 1'b1;
    end else begin
      o.ratio = m_ratio;
      o.en    = m_en;
      o.rdy   = 1'b1;
      o.busy  = 1'b0;
    end
  endtask

  // One clock cycle; optionally pulses the async reset between edges.
  task automatic step(input bit do_rst);
    obs_t o;
    @(posedge clk);
    model_edge(o);
    if (do_rst) begin
      #1 rst = 1'b1;
      #1;
      chk("async_rst_ratio", 32'(div_ratio), 32'd1);
      chk("async_rst_en",    32'(clk_en),    32'd0);
      chk("async_rst_ready", 32'(cfg_ready), 32'd1);
      chk("async_rst_busy",  32'(busy),      32'd0);
      chk("async_rst_err",   32'(cfg_err),   32'd0);
      model_reset();
      o.ratio = 8'd1;
      o.en    = 1'b0;
      o.rdy   = 1'b1;
      o.busy  = 1'b0;
      o.err   = 1'b0;
    end
    exp_q.push_back(o);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      cfg_valid  = 1'b0;
      cfg_ratio  = 8'($urandom);
      cfg_enable = 1'($urandom);
      step(1'b0);
    end
  endtask

  // Hold the request until the model accepts it; valid stays high on return.
  task automatic request(input logic [7:0] r, input logic e);
    int guard;
    guard      = 0;
    cfg_valid  = 1'b1;
    cfg_ratio  = r;
    cfg_enable = e;
    do begin
      step(1'b0);
      guard++;
    end while (!m_acc && guard < 64);
    if (!m_acc) begin
      total++;
      bad++;
      $display("FAIL accept_bound: actual=not accepted required=accepted within 64 cycles");
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("div_ratio", 32'(div_ratio), 32'(e.ratio));
        chk("clk_en",    32'(clk_en),    32'(e.en));
        chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
        chk("busy",      32'(busy),      32'(e.busy));
        chk("cfg_err",   32'(cfg_err),   32'(e.err));
      end
    end
  end

  initial begin : stimulus
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_ratio  = 8'd0;
    cfg_enable = 1'b0;
    n          = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ratio", 32'(div_ratio), 32'd1);
    chk("reset_en",    32'(clk_en),    32'd0);
    chk("reset_ready", 32'(cfg_ready), 32'd1);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_err",   32'(cfg_err),   32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    idle(6);
    request(8'd4, 1'b1);   // switch 1 -> 4
    idle(12);
    request(8'd4, 1'b0);   // same ratio: enable only
    idle(3);
    request(8'd0, 1'b1);   // zero ratio from 4: error pulse, switch to 1
    idle(12);
    request(8'd0, 1'b0);   // zero ratio while already 1
    idle(2);
    request(8'd3, 1'b1);   // switch to 3 ...
    request(8'd7, 1'b1);   // ... with 7 waiting behind it
    idle(14);

    // Reset landing in the settle window of a 7 -> 5 switch.
    request(8'd5, 1'b1);
    idle(S + 2);
    step(1'b1);
    idle(6);

    repeat (40) begin
      request(8'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end
    idle(12);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
